// File: rtl/tl_a_credit_scheduler.sv
// -----------------------------------------------------------------------------
// tl_a_credit_scheduler
// Channel-A scheduler for three TileLink-UL masters feeding one shared port.
// Masters are picked round-robin, and only when they have credit left. The
// winner is held in a one-entry output slot, and its master index is stamped
// onto a_source_out. Outstanding requests per master are tracked by watching
// the Channel-D handshake.
//
// Optional feature macro: TL_A_SCHED_TIMEOUT_EN
//   Adds a per-master response watchdog. When the macro is undefined,
//   timeout_err is tied to zero.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   a_valid / a_ready    per-master request handshake (a_ready is combinational)
//   a_opcode..a_data     packed per-master payload; master i owns slice i
//   a_valid_out          slot valid toward the crossbar
//   a_ready_out          crossbar accept
//   a_*_out              registered payload of the granted request
//   a_source_out         index of the granted master
//   d_valid_in, d_ready_in, d_source_in   observed Channel-D handshake
//   outst_cnt            per-master outstanding count, 3 bits each
//   unexp_d_err          sticky: response arrived for a master with count 0
//   timeout_err          sticky per-master watchdog flag
// -----------------------------------------------------------------------------
module tl_a_credit_scheduler #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned MASK_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned SIZE_WIDTH     = 3,
   parameter int unsigned SRC_WIDTH      = 2,
   parameter int unsigned OPCODE_WIDTH   = 3,
   parameter int unsigned PARAM_WIDTH    = 3,
   parameter int unsigned MAX_OUTST      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [2:0]                a_valid,
   output logic [2:0]                a_ready,
   input  logic [3*OPCODE_WIDTH-1:0] a_opcode,
   input  logic [3*PARAM_WIDTH-1:0]  a_param,
   input  logic [3*SIZE_WIDTH-1:0]   a_size,
   input  logic [3*ADDR_WIDTH-1:0]   a_address,
   input  logic [3*MASK_WIDTH-1:0]   a_mask,
   input  logic [3*DATA_WIDTH-1:0]   a_data,
   output logic                      a_valid_out,
   input  logic                      a_ready_out,
   output logic [OPCODE_WIDTH-1:0]   a_opcode_out,
   output logic [PARAM_WIDTH-1:0]    a_param_out,
   output logic [SIZE_WIDTH-1:0]     a_size_out,
   output logic [ADDR_WIDTH-1:0]     a_address_out,
   output logic [MASK_WIDTH-1:0]     a_mask_out,
   output logic [DATA_WIDTH-1:0]     a_data_out,
   output logic [SRC_WIDTH-1:0]      a_source_out,
   input  logic                      d_valid_in,
   input  logic                      d_ready_in,
   input  logic [SRC_WIDTH-1:0]      d_source_in,
   output logic [8:0]                outst_cnt,
   output logic                      unexp_d_err,
   output logic [2:0]                timeout_err
);

   localparam int unsigned N_MST = 3;
   localparam int unsigned CNT_W = 3;

   // Reject configurations the 3-bit counters or the watchdog cannot represent.
   if (MAX_OUTST < 1 || MAX_OUTST > 7) begin : g_bad_max_outst
      $error("MAX_OUTST must be within 1..7");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic                            w_load_en;
   logic [1:0]                      r_ptr;
   logic [1:0]                      w_sel;
   logic [1:0]                      w_idx;
   logic                            w_sel_valid;
   logic [N_MST-1:0]                w_elig;
   logic [N_MST-1:0]                w_inc;
   logic [N_MST-1:0]                w_dec;
   logic                            w_accept;
   logic                            w_unexp;
   logic [N_MST-1:0][CNT_W-1:0]     r_cnt;
   logic [N_MST-1:0][CNT_W-1:0]     w_cnt_nxt;
   logic                            r_unexp;

   logic [OPCODE_WIDTH-1:0]         w_pl_opcode, r_opcode;
   logic [PARAM_WIDTH-1:0]          w_pl_param,  r_param;
   logic [SIZE_WIDTH-1:0]           w_pl_size,   r_size;
   logic [ADDR_WIDTH-1:0]           w_pl_addr,   r_addr;
   logic [MASK_WIDTH-1:0]           w_pl_mask,   r_mask;
   logic [DATA_WIDTH-1:0]           w_pl_data,   r_data;
   logic [SRC_WIDTH-1:0]            r_source;

   // Eligibility uses the registered count only, so a response arriving in the
   // same cycle does not free a credit until the next cycle.
   always_comb begin
      w_elig = '0;
      for (int unsigned i = 0; i < N_MST; i++) begin
         w_elig[i] = a_valid[i] && (r_cnt[i] < CNT_W'(MAX_OUTST));
      end
   end

   // Round-robin search starting at the master just after the last winner.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel       = '0;
      w_idx       = '0;
      for (int unsigned k = 1; k <= N_MST; k++) begin
         w_idx = 2'((32'(r_ptr) + k) % N_MST);
         if (!w_sel_valid && w_elig[w_idx]) begin
            w_sel_valid = 1'b1;
            w_sel       = w_idx;
         end
      end
   end

   // Slot state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Slot next state and load enable; a draining slot can reload in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_load_en   = 1'b0;
      case (r_state)
         S_EMPTY: w_load_en = 1'b1;
         S_FULL:  w_load_en = a_ready_out;
         default: w_load_en = 1'b0;
      endcase
      if (w_load_en) begin
         w_state_nxt = w_sel_valid ? S_FULL : S_EMPTY;
      end
   end

   // One-hot grant. It is held low while reset is asserted.
   always_comb begin
      a_ready = '0;
      if (reset_n && w_load_en && w_sel_valid) begin
         a_ready[w_sel] = 1'b1;
      end
   end

   assign w_accept = |(a_ready & a_valid);

   // Select the winning master's payload slice.
   always_comb begin
      w_pl_opcode = '0;
      w_pl_param  = '0;
      w_pl_size   = '0;
      w_pl_addr   = '0;
      w_pl_mask   = '0;
      w_pl_data   = '0;
      for (int unsigned i = 0; i < N_MST; i++) begin
         if (w_sel == 2'(i)) begin
            w_pl_opcode = a_opcode [i*OPCODE_WIDTH +: OPCODE_WIDTH];
            w_pl_param  = a_param  [i*PARAM_WIDTH  +: PARAM_WIDTH];
            w_pl_size   = a_size   [i*SIZE_WIDTH   +: SIZE_WIDTH];
            w_pl_addr   = a_address[i*ADDR_WIDTH   +: ADDR_WIDTH];
            w_pl_mask   = a_mask   [i*MASK_WIDTH   +: MASK_WIDTH];
            w_pl_data   = a_data   [i*DATA_WIDTH   +: DATA_WIDTH];
         end
      end
   end

   // Output slot payload, source stamp and round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_opcode <= '0;
         r_param  <= '0;
         r_size   <= '0;
         r_addr   <= '0;
         r_mask   <= '0;
         r_data   <= '0;
         r_source <= '0;
         r_ptr    <= 2'd2;
      end else if (w_accept) begin
         r_opcode <= w_pl_opcode;
         r_param  <= w_pl_param;
         r_size   <= w_pl_size;
         r_addr   <= w_pl_addr;
         r_mask   <= w_pl_mask;
         r_data   <= w_pl_data;
         r_source <= SRC_WIDTH'(w_sel);
         r_ptr    <= w_sel;
      end
   end

   // Credit bookkeeping. A D source of 3 or more matches no master.
   always_comb begin
      w_inc     = '0;
      w_dec     = '0;
      w_cnt_nxt = r_cnt;
      w_unexp   = 1'b0;
      for (int unsigned i = 0; i < N_MST; i++) begin
         w_inc[i] = a_valid[i] && a_ready[i];
         w_dec[i] = d_valid_in && d_ready_in && (d_source_in == SRC_WIDTH'(i));
         if (w_inc[i] && !w_dec[i]) begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
         end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
         end
         if (w_dec[i] && (r_cnt[i] == '0)) begin
            w_unexp = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_unexp <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_unexp) begin
            r_unexp <= 1'b1;
         end
      end
   end

`ifdef TL_A_SCHED_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [N_MST-1:0][WD_W-1:0] r_wd;
   logic [N_MST-1:0]           r_timeout;

   // Watchdog: counts cycles with requests outstanding and no response.
   // It saturates at the limit because the flag is already sticky.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wd      <= '0;
         r_timeout <= '0;
      end else begin
         for (int unsigned i = 0; i < N_MST; i++) begin
            if ((r_cnt[i] == '0) || w_dec[i]) begin
               r_wd[i] <= '0;
            end else if (r_wd[i] != WD_W'(TIMEOUT_CYCLES - 1)) begin
               r_wd[i] <= r_wd[i] + WD_W'(1);
            end
            if (r_wd[i] == WD_W'(TIMEOUT_CYCLES - 1)) begin
               r_timeout[i] <= 1'b1;
            end
         end
      end
   end

   assign timeout_err = r_timeout;
`else
   assign timeout_err = '0;
`endif

   assign a_valid_out   = (r_state == S_FULL);
   assign a_opcode_out  = r_opcode;
   assign a_param_out   = r_param;
   assign a_size_out    = r_size;
   assign a_address_out = r_addr;
   assign a_mask_out    = r_mask;
   assign a_data_out    = r_data;
   assign a_source_out  = r_source;
   assign outst_cnt     = r_cnt;
   assign unexp_d_err   = r_unexp;

endmodule

// File: tb/tb_tl_a_credit_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tl_a_credit_scheduler
// Scoreboard bench. Each stimulus cycle evaluates a reference model of the
// arbitration and credit rules, checks the grant, and queues the expected
// output. A separate monitor pops the queue and compares it with the DUT
// output on every crossbar handshake.
// -----------------------------------------------------------------------------
module tb_tl_a_credit_scheduler;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned MW   = 4;
   localparam int unsigned SW   = 3;
   localparam int unsigned SRCW = 2;
   localparam int unsigned OW   = 3;
   localparam int unsigned PW   = 3;
   localparam int          MAXO = 4;
   localparam int unsigned TO   = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [2:0]        a_valid;
   logic [2:0]        a_ready;
   logic [3*OW-1:0]   a_opcode;
   logic [3*PW-1:0]   a_param;
   logic [3*SW-1:0]   a_size;
   logic [3*AW-1:0]   a_address;
   logic [3*MW-1:0]   a_mask;
   logic [3*DW-1:0]   a_data;
   logic              a_valid_out;
   logic              a_ready_out;
   logic [OW-1:0]     a_opcode_out;
   logic [PW-1:0]     a_param_out;
   logic [SW-1:0]     a_size_out;
   logic [AW-1:0]     a_address_out;
   logic [MW-1:0]     a_mask_out;
   logic [DW-1:0]     a_data_out;
   logic [SRCW-1:0]   a_source_out;
   logic              d_valid_in;
   logic              d_ready_in;
   logic [SRCW-1:0]   d_source_in;
   logic [8:0]        outst_cnt;
   logic              unexp_d_err;
   logic [2:0]        timeout_err;

   always #5 clk = ~clk;

   tl_a_credit_scheduler #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .SIZE_WIDTH(SW),
      .SRC_WIDTH(SRCW), .OPCODE_WIDTH(OW), .PARAM_WIDTH(PW),
      .MAX_OUTST(MAXO), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_ready(a_ready),
      .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
      .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
      .a_valid_out(a_valid_out), .a_ready_out(a_ready_out),
      .a_opcode_out(a_opcode_out), .a_param_out(a_param_out),
      .a_size_out(a_size_out), .a_address_out(a_address_out),
      .a_mask_out(a_mask_out), .a_data_out(a_data_out),
      .a_source_out(a_source_out),
      .d_valid_in(d_valid_in), .d_ready_in(d_ready_in), .d_source_in(d_source_in),
      .outst_cnt(outst_cnt), .unexp_d_err(unexp_d_err), .timeout_err(timeout_err)
   );

   typedef struct {
      logic [OW-1:0]   op;
      logic [PW-1:0]   prm;
      logic [SW-1:0]   sz;
      logic [AW-1:0]   addr;
      logic [MW-1:0]   mask;
      logic [DW-1:0]   data;
      logic [SRCW-1:0] src;
   } txn_t;

   txn_t       exp_q[$];
   txn_t       mon_e;
   int         checks = 0;
   int         errors = 0;

   // Reference model state
   int         m_cnt[3];
   int         m_ptr;
   bit         m_full;
   bit         m_unexp;

   bit         use_force = 1'b0;
   logic [AW-1:0] force_addr = '0;
   logic [2:0] obs_ready;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every crossbar handshake must match the oldest expected grant.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && a_valid_out === 1'b1 && a_ready_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scb_underflow actual=output_fire required=no_output (t=%0t)", $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("scb_source", 128'(a_source_out), 128'(mon_e.src));
            chk("scb_payload",
                128'({a_opcode_out, a_param_out, a_size_out, a_address_out, a_mask_out, a_data_out}),
                128'({mon_e.op, mon_e.prm, mon_e.sz, mon_e.addr, mon_e.mask, mon_e.data}));
         end
      end
   end

   function automatic logic [8:0] model_cnt_vec();
      return {3'(m_cnt[2]), 3'(m_cnt[1]), 3'(m_cnt[0])};
   endfunction

   // One clock of stimulus. Called and returns at posedge+1.
   task automatic step(input logic [2:0] av, input logic rdy, input logic dv,
                       input logic dr, input logic [1:0] ds);
      int            sel;
      bit            load;
      logic [2:0]    exp_ready;
      txn_t          t;
      bit            hold;
      logic [127:0]  held;
      bit            inc, dec;
      a_valid     = av;
      a_ready_out = rdy;
      d_valid_in  = dv;
      d_ready_in  = dr;
      d_source_in = ds;
      for (int i = 0; i < 3; i++) begin
         a_opcode [i*OW +: OW] = OW'($urandom);
         a_param  [i*PW +: PW] = PW'($urandom);
         a_size   [i*SW +: SW] = SW'($urandom);
         a_address[i*AW +: AW] = use_force ? force_addr : AW'($urandom);
         a_mask   [i*MW +: MW] = MW'($urandom);
         a_data   [i*DW +: DW] = DW'($urandom);
      end
      #1;
      // The slot may take a new request when empty or when draining this cycle.
      // The winner is the first master with credit, counting up from the last winner.
      load = !m_full || rdy;
      sel  = -1;
      for (int k = 1; k <= 3; k++) begin
         int idx;
         idx = (m_ptr + k) % 3;
         if (sel < 0 && av[idx] && m_cnt[idx] < MAXO) sel = idx;
      end
      exp_ready = (load && sel >= 0) ? (3'b001 << sel) : 3'b000;
      obs_ready = a_ready;
      chk("a_ready", 128'(a_ready), 128'(exp_ready));
      if (load && sel >= 0) begin
         t.op   = a_opcode [sel*OW +: OW];
         t.prm  = a_param  [sel*PW +: PW];
         t.sz   = a_size   [sel*SW +: SW];
         t.addr = a_address[sel*AW +: AW];
         t.mask = a_mask   [sel*MW +: MW];
         t.data = a_data   [sel*DW +: DW];
         t.src  = SRCW'(sel);
         exp_q.push_back(t);
      end
      hold = m_full && !rdy;
      held = 128'({a_opcode_out, a_param_out, a_size_out, a_address_out,
                   a_mask_out, a_data_out, a_source_out});
      for (int i = 0; i < 3; i++) begin
         inc = load && (sel == i);
         dec = dv && dr && (int'(ds) == i);
         if (dec && m_cnt[i] == 0) m_unexp = 1'b1;
         if (inc && !dec) m_cnt[i]++;
         else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
      end
      if (load) begin
         m_full = (sel >= 0);
         if (sel >= 0) m_ptr = sel;
      end
      @(posedge clk);
      #1;
      chk("outst_cnt", 128'(outst_cnt), 128'(model_cnt_vec()));
      chk("a_valid_out", 128'(a_valid_out), 128'(m_full));
      chk("unexp_d_err", 128'(unexp_d_err), 128'(m_unexp));
`ifndef TL_A_SCHED_TIMEOUT_EN
      chk("timeout_err", 128'(timeout_err), 128'(3'b000));
`endif
      if (hold) begin
         chk("slot_hold",
             128'({a_opcode_out, a_param_out, a_size_out, a_address_out,
                   a_mask_out, a_data_out, a_source_out}), held);
      end
   endtask

   // Asynchronous reset pulse that starts mid-cycle. The immediate-clear checks follow it.
   task automatic do_reset();
      a_valid     = 3'b111;
      a_ready_out = 1'b1;
      d_valid_in  = 1'b0;
      d_ready_in  = 1'b0;
      d_source_in = '0;
      #1 reset_n = 1'b0;
      #1;
      chk("rst_valid_out", 128'(a_valid_out), 128'(1'b0));
      chk("rst_outst_cnt", 128'(outst_cnt), 128'(9'd0));
      chk("rst_a_ready", 128'(a_ready), 128'(3'b000));
      chk("rst_flags", 128'({unexp_d_err, timeout_err, a_source_out, a_address_out}), 128'(0));
      exp_q.delete();
      m_cnt   = '{0, 0, 0};
      m_ptr   = 2;
      m_full  = 1'b0;
      m_unexp = 1'b0;
      @(negedge clk);
      a_valid = 3'b000;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) step(3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("queue_empty", 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      logic [1:0] ds;
      int         cands[$];
      reset_n     = 1'b0;
      a_valid     = '0;
      a_ready_out = 1'b0;
      d_valid_in  = 1'b0;
      d_ready_in  = 1'b0;
      d_source_in = '0;
      a_opcode = '0; a_param = '0; a_size = '0; a_address = '0; a_mask = '0; a_data = '0;
      repeat (2) @(posedge clk);
      do_reset();

      // Round-robin order from reset: 0,1,2,0
      step(3'b111, 1'b1, 1'b0, 1'b0, 2'd0); chk("rr_grant0", 128'(obs_ready), 128'(3'b001));
      step(3'b111, 1'b1, 1'b0, 1'b0, 2'd0); chk("rr_grant1", 128'(obs_ready), 128'(3'b010));
      step(3'b111, 1'b1, 1'b0, 1'b0, 2'd0); chk("rr_grant2", 128'(obs_ready), 128'(3'b100));
      step(3'b111, 1'b1, 1'b0, 1'b0, 2'd0); chk("rr_grant3", 128'(obs_ready), 128'(3'b001));
      drain();

      // Credit limit on master 1
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(3'b010, 1'b1, 1'b0, 1'b0, 2'd0);
         chk("credit_accept", 128'(obs_ready), 128'(3'b010));
      end
      for (int i = 0; i < 2; i++) begin
         step(3'b010, 1'b1, 1'b0, 1'b0, 2'd0);
         chk("credit_block", 128'(obs_ready), 128'(3'b000));
      end
      step(3'b010, 1'b1, 1'b1, 1'b1, 2'd1);
      chk("credit_d_cycle", 128'(obs_ready), 128'(3'b000));
      step(3'b010, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("credit_fifth", 128'(obs_ready), 128'(3'b010));
      drain();

      // Backpressure holds the slot
      do_reset();
      use_force  = 1'b1;
      force_addr = 32'h0000_1000;
      step(3'b001, 1'b1, 1'b0, 1'b0, 2'd0);
      use_force  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(3'b001, 1'b0, 1'b0, 1'b0, 2'd0);
         chk("bp_a_ready", 128'(obs_ready), 128'(3'b000));
         chk("bp_valid", 128'(a_valid_out), 128'(1'b1));
         chk("bp_addr", 128'(a_address_out), 128'(32'h0000_1000));
      end
      drain();

      // Simultaneous increment and decrement, then an unexpected response
      do_reset();
      step(3'b100, 1'b1, 1'b0, 1'b0, 2'd0);
      step(3'b100, 1'b1, 1'b0, 1'b0, 2'd0);
      step(3'b100, 1'b1, 1'b1, 1'b1, 2'd2);
      chk("inc_dec_cnt2", 128'(outst_cnt[8:6]), 128'(3'd2));
      step(3'b000, 1'b1, 1'b1, 1'b1, 2'd0);
      chk("unexp_flag", 128'(unexp_d_err), 128'(1'b1));
      chk("unexp_cnt0", 128'(outst_cnt[2:0]), 128'(3'd0));
      step(3'b000, 1'b1, 1'b1, 1'b1, 2'd3);
      drain();

      // Reset while the slot is full and counts are {3,1,2}
      do_reset();
      repeat (3) step(3'b001, 1'b1, 1'b0, 1'b0, 2'd0);
      step(3'b010, 1'b1, 1'b0, 1'b0, 2'd0);
      repeat (2) step(3'b100, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("pre_rst_cnt", 128'(outst_cnt), 128'({3'd2, 3'd1, 3'd3}));
      chk("pre_rst_full", 128'(a_valid_out), 128'(1'b1));
      do_reset();
      step(3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("post_rst_grant", 128'(obs_ready), 128'(3'b001));
      drain();

`ifdef TL_A_SCHED_TIMEOUT_EN
      // Watchdog: no response trips it; an early response keeps it clear.
      do_reset();
      step(3'b001, 1'b1, 1'b0, 1'b0, 2'd0);
      repeat (20) step(3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("wd_trip", 128'(timeout_err[0]), 128'(1'b1));
      do_reset();
      step(3'b001, 1'b1, 1'b0, 1'b0, 2'd0);
      repeat (8) step(3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
      step(3'b000, 1'b1, 1'b1, 1'b1, 2'd0);
      repeat (12) step(3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("wd_clear", 128'(timeout_err), 128'(3'b000));
`endif

      // Random traffic. Responses target only masters the model has credit out for.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         cands.delete();
         for (int i = 0; i < 3; i++) if (m_cnt[i] > 0) cands.push_back(i);
         if (cands.size() == 0 || $urandom_range(0, 7) == 0) ds = 2'd3;
         else ds = 2'(cands[$urandom_range(0, cands.size() - 1)]);
         step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ds);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
